// File: rtl/timing_sequencer.sv
// Sequence counter with start/stop (S) flip-flop for the basic-computer
// control unit. Produces a registered one-hot timing vector T0..T(WIDTH-1)
// together with its binary count. All outputs are registered; there is no
// combinational path from any input to any output.
//
// The S flip-flop is the FSM state: running is high exactly in RUN, so the
// state is always observable on the running output.
//
// Control priority inside RUN (highest first): reset > stop > clear > increment.
// In HALT, start (without stop) enters RUN at T0; clear zeroes the held count.
module timing_sequencer #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic [WIDTH-1:0]       timing_out
);

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COUNT_WIDTH-1:0] sc;
  logic [COUNT_WIDTH-1:0] sc_next;
  logic [WIDTH-1:0]       t;
  logic [WIDTH-1:0]       t_next;

  localparam logic [WIDTH-1:0] T0 = {{(WIDTH-1){1'b0}}, 1'b1};

  // Next-state, next-count and next-timing-vector decode.
  always_comb begin
    state_next = state;
    sc_next    = sc;
    unique case (state)
      HALT: begin
        if (start && !stop) begin
          state_next = RUN;
          sc_next    = '0;
        end else if (clear) begin
          sc_next = '0;
        end
      end
      RUN: begin
        if (stop) begin
          // Halting keeps the count unless clear lands on the same edge.
          state_next = HALT;
          if (clear) sc_next = '0;
        end else if (clear) begin
          sc_next = '0;
        end else begin
          // WIDTH is a power of two, so the natural roll-over is modulo WIDTH.
          sc_next = sc + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = HALT;
        sc_next    = '0;
      end
    endcase
    // The timing vector is derived from the next count so it is always the
    // one-hot image of count_out while running, and all-zero while halted.
    t_next = (state_next == RUN) ? (T0 << sc_next) : '0;
  end

  // State, count and timing registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HALT;
      sc    <= '0;
      t     <= '0;
    end else begin
      state <= state_next;
      sc    <= sc_next;
      t     <= t_next;
    end
  end

  assign running    = (state == RUN);
  assign count_out  = sc;
  assign timing_out = t;

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: reset/idle, free run with wrap, clear,
// stop/resume, simultaneous controls, then a short random run checked against
// a small reference model and an 8-to-3 encoder on timing_out.
module tb_timing_sequencer;

  localparam int WIDTH = 8;
  localparam int CW    = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic             stop;
  logic             clear;
  logic             running;
  logic [CW-1:0]    count_out;
  logic [WIDTH-1:0] timing_out;

  int checks = 0;
  int errors = 0;

  timing_sequencer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .running    (running),
    .count_out  (count_out),
    .timing_out (timing_out)
  );

  // Clock: 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 8-to-3 encoder on the timing vector.
  logic [CW-1:0] enc;
  always_comb begin
    enc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (timing_out[i]) enc = CW'(i);
    end
  end

  // Apply one cycle of controls, then sample 1 time unit after the edge.
  task automatic step(input logic st, input logic sp, input logic cl, input logic rs);
    start = st;
    stop  = sp;
    clear = cl;
    reset = rs;
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against hand-computed values.
  task automatic check(input string tag, input logic exp_run, input logic [CW-1:0] exp_cnt,
                       input logic [WIDTH-1:0] exp_t);
    checks++;
    assert (running === exp_run && count_out === exp_cnt && timing_out === exp_t)
    else begin
      errors++;
      $error("FAIL %s: observed run=%b cnt=%0d t=%h expected run=%b cnt=%0d t=%h",
             tag, running, count_out, timing_out, exp_run, exp_cnt, exp_t);
    end
  endtask

  logic [WIDTH-1:0] exp_seq [8];
  logic             m_run;
  logic [CW-1:0]    m_cnt;
  logic             r_st, r_sp, r_cl;

  initial begin
    exp_seq[0] = 8'h02; exp_seq[1] = 8'h04; exp_seq[2] = 8'h08; exp_seq[3] = 8'h10;
    exp_seq[4] = 8'h20; exp_seq[5] = 8'h40; exp_seq[6] = 8'h80; exp_seq[7] = 8'h01;

    start = 0; stop = 0; clear = 0; reset = 1;
    #1;

    // Reset held two cycles with start asserted.
    step(1, 0, 0, 1); check("reset_c1", 0, 0, 8'h00);
    step(1, 0, 0, 1); check("reset_c2", 0, 0, 8'h00);
    // Idle after release.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0); check("idle", 0, 0, 8'h00);
    end

    // Start pulse, then free run through the wrap.
    step(1, 0, 0, 0); check("start_t0", 1, 0, 8'h01);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0); check("free_run", 1, CW'(i + 1), exp_seq[i]);
    end

    // Clear mid-sequence at count 5.
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0);
    check("at_5", 1, 5, 8'h20);
    step(0, 0, 1, 0); check("clear", 1, 0, 8'h01);
    step(0, 0, 0, 0); check("after_clear", 1, 1, 8'h02);

    // Stop at count 3, hold, resume.
    step(0, 0, 0, 0); step(0, 0, 0, 0); check("at_3", 1, 3, 8'h08);
    step(0, 1, 0, 0); check("stop", 0, 3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0); check("halt_hold", 0, 3, 8'h00);
    end
    step(1, 0, 0, 0); check("resume", 1, 0, 8'h01);

    // start+stop in RUN at count 2: stop wins, count held.
    step(0, 0, 0, 0); step(0, 0, 0, 0); check("at_2", 1, 2, 8'h04);
    step(1, 1, 0, 0); check("start_stop", 0, 2, 8'h00);
    step(1, 1, 0, 0); check("start_stop_halt", 0, 2, 8'h00);

    // stop+clear at count 6: halt with count zeroed.
    step(1, 0, 0, 0); check("restart", 1, 0, 8'h01);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    check("at_6", 1, 6, 8'h40);
    step(0, 1, 1, 0); check("stop_clear", 0, 0, 8'h00);

    // clear while halted zeroes a held count.
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    check("at_3b", 1, 3, 8'h08);
    step(0, 1, 0, 0); check("stop_b", 0, 3, 8'h00);
    step(0, 0, 1, 0); check("halt_clear", 0, 0, 8'h00);

    // start+reset in HALT: stays halted.
    step(1, 0, 0, 1); check("start_reset_halt", 0, 0, 8'h00);
    step(0, 0, 0, 0); check("post_reset_halt", 0, 0, 8'h00);

    // Reset mid-sequence with start: back to HALT/0/0.
    step(1, 0, 0, 0); for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("at_4", 1, 4, 8'h10);
    step(1, 0, 0, 1); check("reset_mid", 0, 0, 8'h00);
    step(0, 0, 0, 0); check("reset_mid_idle", 0, 0, 8'h00);

    // Random controls against a reference model plus encoder invariants.
    m_run = 0;
    m_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      r_st = 1'($urandom_range(0, 1));
      r_sp = ($urandom_range(0, 4) == 0);
      r_cl = ($urandom_range(0, 3) == 0);
      if (m_run) begin
        if (r_sp) begin
          m_run = 0;
          if (r_cl) m_cnt = 0;
        end else if (r_cl) m_cnt = 0;
        else m_cnt = m_cnt + 1'b1;
      end else begin
        if (r_st && !r_sp) begin
          m_run = 1;
          m_cnt = 0;
        end else if (r_cl) m_cnt = 0;
      end
      step(r_st, r_sp, r_cl, 0);
      check("rand_model", m_run, m_cnt, m_run ? (8'h01 << m_cnt) : 8'h00);
      checks++;
      if (running) begin
        assert (enc === count_out && $countones(timing_out) == 1)
        else begin
          errors++;
          $error("FAIL enc_run: observed enc=%0d ones=%0d t=%h expected enc=%0d ones=1",
                 enc, $countones(timing_out), timing_out, count_out);
        end
      end else begin
        assert (timing_out === 8'h00)
        else begin
          errors++;
          $error("FAIL halt_zero: observed t=%h expected t=00", timing_out);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
